// File: rtl/mem_port_sequencer.sv
// Arbitrates the single data-memory port between instruction fetch and load/store,
// decoding SPARC op3, checking alignment, steering byte lanes and bounding every access.
module mem_port_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_data,
  output logic        if_trap,
  input  logic        d_req,
  input  logic [5:0]  d_op3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_trap,
  output logic [1:0]  trap_cause,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_mfc
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_last_data;
  logic        r_is_data;
  size_t       r_size;
  logic        r_signed;
  logic        r_write;
  logic [1:0]  r_off;
  logic [7:0]  r_cnt;

  logic        w_pick_data;
  logic [31:0] w_addr;
  size_t       w_size;
  logic        w_signed;
  logic        w_write;
  logic        w_illegal;
  logic        w_misal;
  logic [1:0]  w_cause;
  logic [3:0]  w_be;
  logic [31:0] w_lanes;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_timeout;

  // On contention the requester not served last wins; r_last_data resets to data so fetch goes first.
  always_comb begin
    w_pick_data = d_req && (!if_req || !r_last_data);
    w_addr      = w_pick_data ? d_addr : if_addr;
    w_size      = SZ_WORD;
    w_signed    = 1'b0;
    w_write     = 1'b0;
    w_illegal   = 1'b0;
    if (w_pick_data) begin
      case (d_op3)
        6'b001001: begin w_size = SZ_BYTE; w_signed = 1'b1; end
        6'b001010: begin w_size = SZ_HALF; w_signed = 1'b1; end
        6'b000001: w_size = SZ_BYTE;
        6'b000010: w_size = SZ_HALF;
        6'b000000: w_size = SZ_WORD;
        6'b000101: begin w_size = SZ_BYTE; w_write = 1'b1; end
        6'b000110: begin w_size = SZ_HALF; w_write = 1'b1; end
        6'b000100: begin w_size = SZ_WORD; w_write = 1'b1; end
        default:   w_illegal = 1'b1;
      endcase
    end
    w_misal = ((w_size == SZ_HALF) && w_addr[0]) ||
              ((w_size == SZ_WORD) && (w_addr[1:0] != 2'b00));
    w_cause = w_illegal ? 2'b10 : (w_misal ? 2'b01 : 2'b00);
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'b1000 >> w_addr[1:0];
        w_lanes = {4{d_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be    = w_addr[1] ? 4'b0011 : 4'b1100;
        w_lanes = {2{d_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_lanes = d_wdata;
      end
    endcase
  end

  // Big-endian lane extraction followed by sign/zero extension; stores return 0.
  always_comb begin
    case (r_off)
      2'd0:    w_byte = mem_rdata[31:24];
      2'd1:    w_byte = mem_rdata[23:16];
      2'd2:    w_byte = mem_rdata[15:8];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (r_size)
      SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
    if (r_write) w_load = '0;
    w_timeout = (r_cnt == LP_CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_data <= 1'b1;
      r_is_data   <= 1'b0;
      r_size      <= SZ_WORD;
      r_signed    <= 1'b0;
      r_write     <= 1'b0;
      r_off       <= '0;
      r_cnt       <= '0;
      if_ack      <= 1'b0;
      if_data     <= '0;
      if_trap     <= 1'b0;
      d_ack       <= 1'b0;
      d_rdata     <= '0;
      d_trap      <= 1'b0;
      trap_cause  <= '0;
      mem_en      <= 1'b0;
      mem_rw      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (if_req || d_req) begin
            r_is_data <= w_pick_data;
            r_size    <= w_size;
            r_signed  <= w_signed;
            r_write   <= w_write;
            r_off     <= w_addr[1:0];
            r_cnt     <= '0;
            if (w_illegal || w_misal) begin
              r_state    <= RESP;
              trap_cause <= w_cause;
              if (w_pick_data) begin
                d_ack   <= 1'b1;
                d_trap  <= 1'b1;
                d_rdata <= '0;
              end else begin
                if_ack  <= 1'b1;
                if_trap <= 1'b1;
                if_data <= '0;
              end
            end else begin
              r_state   <= WAIT;
              mem_en    <= 1'b1;
              mem_rw    <= ~w_write;
              mem_addr  <= {w_addr[31:2], 2'b00};
              mem_be    <= w_be;
              mem_wdata <= w_lanes;
            end
          end
        end
        WAIT: begin
          // An mfc arriving in the final watchdog cycle still completes normally.
          if (mem_mfc || w_timeout) begin
            r_state    <= RESP;
            mem_en     <= 1'b0;
            trap_cause <= mem_mfc ? 2'b00 : 2'b11;
            if (r_is_data) begin
              d_ack   <= 1'b1;
              d_trap  <= ~mem_mfc;
              d_rdata <= mem_mfc ? w_load : '0;
            end else begin
              if_ack  <= 1'b1;
              if_trap <= ~mem_mfc;
              if_data <= mem_mfc ? mem_rdata : '0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_last_data <= r_is_data;
          if_trap     <= 1'b0;
          if_data     <= '0;
          d_trap      <= 1'b0;
          d_rdata     <= '0;
          trap_cause  <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Scoreboard bench for mem_port_sequencer: expectations queued at request time, checked on ack.
module tb_mem_port_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_data;
  logic        if_trap;
  logic        d_req = 1'b0;
  logic [5:0]  d_op3 = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_trap;
  logic [1:0]  trap_cause;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_mfc = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int mfc_delay = 0;
  int resp_cnt = 0;

  typedef struct {
    bit          isd;
    logic [31:0] data;
    logic        trap;
    logic [1:0]  cause;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  mem_port_sequencer #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data), .if_trap(if_trap),
    .d_req(d_req), .d_op3(d_op3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_trap(d_trap), .trap_cause(trap_cause),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_mfc(mem_mfc)
  );

  always #5 clk = ~clk;

  // Memory model: raises mfc after mfc_delay extra cycles of mem_en.
  always @(negedge clk) begin
    if (mem_en) begin
      mem_mfc = (resp_cnt == mfc_delay);
      resp_cnt++;
    end else begin
      mem_mfc = 1'b0;
      resp_cnt = 0;
    end
  end

  task automatic compare_ack(input exp_t e, input int edges, input string name);
    logic [31:0] got_data;
    logic        got_trap;
    n_tests++;
    if ((e.isd ? (!d_ack || if_ack) : (!if_ack || d_ack)) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s kind: if_ack=%b d_ack=%b expected data-side=%b", name, if_ack, d_ack, e.isd);
    end
    got_data = e.isd ? d_rdata : if_data;
    got_trap = e.isd ? d_trap : if_trap;
    n_tests++;
    if (got_data !== e.data) begin
      n_fail++;
      $display("FAIL %s data: got %h expected %h", name, got_data, e.data);
    end
    n_tests++;
    if (got_trap !== e.trap) begin
      n_fail++;
      $display("FAIL %s trap: got %b expected %b", name, got_trap, e.trap);
    end
    n_tests++;
    if (trap_cause !== e.cause) begin
      n_fail++;
      $display("FAIL %s cause: got %b expected %b", name, trap_cause, e.cause);
    end
    n_tests++;
    if (edges !== e.cyc) begin
      n_fail++;
      $display("FAIL %s latency: ack in cycle %0d expected %0d", name, edges, e.cyc);
    end
  endtask

  task automatic access(input bit isd, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int dly,
                        input logic [31:0] exp_data, input logic [1:0] exp_cause,
                        input logic [3:0] exp_be, input logic [31:0] exp_mw,
                        input logic exp_rw, input int exp_cyc, input string name);
    exp_t e;
    int   edges;
    int   en_cycles;
    int   exp_en;
    bit   done;
    logic [31:0] exp_maddr;
    exp_maddr = {addr[31:2], 2'b00};
    e = '{isd, exp_data, (exp_cause != 2'b00), exp_cause, exp_cyc};
    sb.push_back(e);
    mem_rdata = rd;
    mfc_delay = dly;
    if (isd) begin
      d_req = 1'b1; d_op3 = op; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    edges = 0; en_cycles = 0; done = 1'b0;
    while (!done && edges < 40) begin
      @(negedge clk);
      edges++;
      if (mem_en) begin
        en_cycles++;
        if (en_cycles == 1) begin
          n_tests++;
          if (mem_rw !== exp_rw || mem_addr !== exp_maddr || mem_be !== exp_be) begin
            n_fail++;
            $display("FAIL %s mem ctl: rw=%b addr=%h be=%b expected rw=%b addr=%h be=%b",
                     name, mem_rw, mem_addr, mem_be, exp_rw, exp_maddr, exp_be);
          end
          if (!exp_rw) begin
            n_tests++;
            if (mem_wdata !== exp_mw) begin
              n_fail++;
              $display("FAIL %s mem_wdata: got %h expected %h", name, mem_wdata, exp_mw);
            end
          end
        end
      end
      if (if_ack || d_ack) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL %s unexpected ack with empty scoreboard", name);
        end else begin
          e = sb.pop_front();
          compare_ack(e, edges, name);
        end
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s no ack within 40 cycles", name);
      void'(sb.pop_front());
    end
    exp_en = (exp_cause == 2'b00) ? dly + 1 : ((exp_cause == 2'b11) ? 15 : 0);
    n_tests++;
    if (en_cycles !== exp_en) begin
      n_fail++;
      $display("FAIL %s mem_en cycles: got %0d expected %0d", name, en_cycles, exp_en);
    end
    @(negedge clk);
    n_tests++;
    if ({if_ack, d_ack, mem_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s after ack: if_ack=%b d_ack=%b mem_en=%b expected 000", name, if_ack, d_ack, mem_en);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({if_ack, if_data, if_trap, d_ack, d_rdata, d_trap, trap_cause} !== '0) begin
      n_fail++;
      $display("FAIL reset acks: if_ack=%b if_data=%h d_ack=%b d_rdata=%h cause=%b expected all 0",
               if_ack, if_data, d_ack, d_rdata, trap_cause);
    end
    n_tests++;
    if ({mem_en, mem_rw, mem_addr, mem_be, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset mem: en=%b rw=%b addr=%h be=%b wdata=%h expected all 0",
               mem_en, mem_rw, mem_addr, mem_be, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    access(1'b0, 6'd0, 32'h100, 32'h0, 32'h81C3E008, 0, 32'h81C3E008, 2'b00, 4'b1111, 32'h0, 1'b1, 2, "fetch");
    access(1'b0, 6'd0, 32'h140, 32'h0, 32'h01000000, 2, 32'h01000000, 2'b00, 4'b1111, 32'h0, 1'b1, 4, "fetch_wait2");
  endtask

  task automatic test_load;
    access(1'b1, 6'b001001, 32'h203, 32'h0, 32'h000000F0, 0, 32'hFFFFFFF0, 2'b00, 4'b0001, 32'h0, 1'b1, 2, "ldsb");
    access(1'b1, 6'b000001, 32'h203, 32'h0, 32'h000000F0, 0, 32'h000000F0, 2'b00, 4'b0001, 32'h0, 1'b1, 2, "ldub");
    access(1'b1, 6'b001010, 32'h202, 32'h0, 32'h00008001, 0, 32'hFFFF8001, 2'b00, 4'b0011, 32'h0, 1'b1, 2, "ldsh");
    access(1'b1, 6'b000010, 32'h200, 32'h0, 32'h80017FFF, 1, 32'h00008001, 2'b00, 4'b1100, 32'h0, 1'b1, 3, "lduh");
    access(1'b1, 6'b001001, 32'h201, 32'h0, 32'h12805634, 0, 32'hFFFFFF80, 2'b00, 4'b0100, 32'h0, 1'b1, 2, "ldsb_lane1");
    access(1'b1, 6'b000000, 32'h204, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2'b00, 4'b1111, 32'h0, 1'b1, 2, "ld");
  endtask

  task automatic test_store;
    access(1'b1, 6'b000110, 32'h106, 32'h1234ABCD, 32'hFFFFFFFF, 0, 32'h0, 2'b00, 4'b0011, 32'hABCDABCD, 1'b0, 2, "sth");
    access(1'b1, 6'b000101, 32'h101, 32'h000000A5, 32'hFFFFFFFF, 0, 32'h0, 2'b00, 4'b0100, 32'hA5A5A5A5, 1'b0, 2, "stb");
    access(1'b1, 6'b000100, 32'h10C, 32'h01020304, 32'hFFFFFFFF, 0, 32'h0, 2'b00, 4'b1111, 32'h01020304, 1'b0, 2, "st");
  endtask

  task automatic test_errors;
    access(1'b1, 6'b000000, 32'h102, 32'h0, 32'h0, 0, 32'h0, 2'b01, 4'b0, 32'h0, 1'b1, 1, "ld_misaligned");
    access(1'b1, 6'b111111, 32'h101, 32'h0, 32'h0, 0, 32'h0, 2'b10, 4'b0, 32'h0, 1'b1, 1, "illegal_op3");
    access(1'b1, 6'b001010, 32'h101, 32'h0, 32'h0, 0, 32'h0, 2'b01, 4'b0, 32'h0, 1'b1, 1, "ldsh_misaligned");
    access(1'b1, 6'b000110, 32'h103, 32'h0, 32'h0, 0, 32'h0, 2'b01, 4'b0, 32'h0, 1'b0, 1, "sth_misaligned");
    access(1'b0, 6'd0, 32'h102, 32'h0, 32'h0, 0, 32'h0, 2'b01, 4'b0, 32'h0, 1'b1, 1, "fetch_misaligned");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   edges;
    int   acks;
    test_reset();
    mem_rdata = 32'hCAFEF00D;
    mfc_delay = 0;
    sb.push_back('{1'b0, 32'hCAFEF00D, 1'b0, 2'b00, 2});
    sb.push_back('{1'b1, 32'hCAFEF00D, 1'b0, 2'b00, 5});
    sb.push_back('{1'b0, 32'hCAFEF00D, 1'b0, 2'b00, 8});
    sb.push_back('{1'b1, 32'hCAFEF00D, 1'b0, 2'b00, 11});
    if_addr = 32'h400; d_addr = 32'h800; d_op3 = 6'b000000;
    if_req = 1'b1; d_req = 1'b1;
    edges = 0; acks = 0;
    while (acks < 4 && edges < 40) begin
      @(negedge clk);
      edges++;
      if (if_ack || d_ack) begin
        acks++;
        e = sb.pop_front();
        compare_ack(e, edges, "contention");
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    n_tests++;
    if (acks != 4) begin
      n_fail++;
      $display("FAIL contention ack count: got %0d expected 4", acks);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    access(1'b1, 6'b000000, 32'h300, 32'h0, 32'h11111111, 1000, 32'h0, 2'b11, 4'b1111, 32'h0, 1'b1, 16, "timeout");
    access(1'b0, 6'd0, 32'h304, 32'h0, 32'h22222222, 1000, 32'h0, 2'b11, 4'b1111, 32'h0, 1'b1, 16, "fetch_timeout");
    access(1'b1, 6'b000000, 32'h308, 32'h0, 32'h33333333, 14, 32'h33333333, 2'b00, 4'b1111, 32'h0, 1'b1, 16, "mfc_at_last_cycle");
  endtask

  task automatic test_reset_mid;
    bit bad_ack;
    mfc_delay = 1000;
    d_op3 = 6'b000000; d_addr = 32'h400; d_req = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid setup: mem_en=%b expected 1", mem_en);
    end
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid mem_en: got %b expected 0", mem_en);
    end
    reset = 1'b0;
    bad_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (if_ack || d_ack || mem_en) bad_ack = 1'b1;
    end
    n_tests++;
    if (bad_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid spurious: ack or mem_en seen=%b expected 0", bad_ack);
    end
    access(1'b1, 6'b000000, 32'h404, 32'h0, 32'h5A5A0001, 0, 32'h5A5A0001, 2'b00, 4'b1111, 32'h0, 1'b1, 2, "after_reset");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_errors();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard leftover: %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
